// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, with sign
// handling, divide-by-zero short path and annul (flush) support.
module div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    StIdle,
    StDivZero,
    StOn,
    StEnd
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  // Operand preparation: magnitudes and result signs for signed division
  logic                 neg1, neg2;
  logic [WIDTH-1:0]     abs1, abs2;

  always_comb begin
    neg1 = signed_div & opdata1[WIDTH-1];
    neg2 = signed_div & opdata2[WIDTH-1];
    abs1 = neg1 ? -opdata1 : opdata1;
    abs2 = neg2 ? -opdata2 : opdata2;
  end

  // One restoring step: {partial remainder, quotient} shifted left, trial subtract on top
  logic [2*WIDTH:0]     step_sh;
  logic [WIDTH:0]       step_diff;
  logic [2*WIDTH:0]     step_rem;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    step_sh   = rem_q << 1;
    step_diff = step_sh[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    if (step_diff[WIDTH]) begin
      step_rem = step_sh;
    end else begin
      step_rem = {step_diff, step_sh[WIDTH-1:1], 1'b1};
    end
    quo_fix = qneg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
    rem_fix = rneg_q ? -step_rem[2*WIDTH-1:WIDTH] : step_rem[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !annul) begin
          rem_d     = {{(WIDTH+1){1'b0}}, abs1};
          divisor_d = abs2;
          qneg_d    = neg1 ^ neg2;
          rneg_d    = neg1;
          cnt_d     = '0;
          state_d   = (opdata2 == '0) ? StDivZero : StOn;
        end
      end
      StDivZero: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          result_d = '0;
          state_d  = StEnd;
        end
      end
      StOn: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          cnt_d = cnt_q + 1'b1;
          // Last of WIDTH steps: sign-correct straight into the result register
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = {rem_fix, quo_fix};
            state_d  = StEnd;
          end
        end
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StEnd);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule
